uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised UART receiver with configurable frame format, glitch-rejecting start detection, a show-ahead receive FIFO with valid/ready output, and sticky error flags. It replaces the fixed 8N1 single-byte receiver feeding the echo path and LEDs. Downstream logic drains bytes at its own pace without losing back-to-back frames.

Parameters:
CLKS_PER_BIT, 104, iCE_CLK cycles per UART bit; 12 MHz / 115200; minimum 8.
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
FIFO_DEPTH, 4, FIFO entries; power of 2, at least 2.
SYNC_STAGES, 2, RX synchroniser flops, at least 2.

Ports:
iCE_CLK  input  1  system clock; all logic on its rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
RX  input  1  asynchronous serial line; idle high.
rx_data  output  DATA_BITS  FIFO head entry; valid while rx_valid=1.
rx_valid  output  1  FIFO not empty.
rx_ready  input  1  consumer accepts head when rx_valid & rx_ready.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries held.
frame_err  output  1  sticky: stop bit sampled low.
parity_err  output  1  sticky: parity mismatch.
overrun  output  1  sticky: good frame arrived while FIFO full.
clr_err  input  1  1-cycle pulse; clears all three sticky flags.

Behaviour:
- Reset (async, rst_n=0):
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - FIFO empty: rx_valid=0, fifo_count=0, rx_data=0.
  - All error flags = 0.
  - armed = 0.
- armed sets after the synchronised RX is seen high for one cycle. A start is never detected while armed=0, so a line held low through reset release causes no false frame.
- States: IDLE, START, DATA, PARITY (only when PARITY!=0), STOP, BREAK.
- IDLE: a synchronised 1->0 transition with armed=1 moves to START and zeroes the bit counter.
- START: at count CLKS_PER_BIT/2-1, sample RX.
  - Low: go to DATA with count reset.
  - High: glitch; return to IDLE with no flag.
- DATA: sample at each mid-bit, i.e. every CLKS_PER_BIT cycles after the start mid-point.
  - Shift bits LSB first.
  - After DATA_BITS samples, go to PARITY or STOP.
- PARITY: sample one bit.
  - Odd: XOR of data and parity bit must be 1.
  - Even: XOR must be 0.
  - Mismatch is remembered for STOP.
- STOP: sample at mid-bit.
  - Low: frame_err=1, no push, go to BREAK.
  - High with a parity mismatch: parity_err=1, no push, go to IDLE.
  - High and good: push to FIFO, go to IDLE.
- BREAK: wait for synchronised RX = 1, then go to IDLE.
- Push timing: the push happens in the stop-sample cycle. rx_valid/fifo_count update on the next edge.
- FIFO is show-ahead. rx_data shows the head combinationally from storage; 0 is not required when empty.
- Pop occurs when rx_valid & rx_ready; the head advances on the next edge.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Push while full with no pop in the same cycle: the byte is dropped, overrun=1, and contents are unchanged.
- Push while full with a pop in the same cycle: both happen; fifo_count stays FIFO_DEPTH and overrun is not set.
- Push and pop on a non-full, non-empty FIFO: count is unchanged.
- rx_ready while empty: ignored, count stays 0.
- clr_err in the same cycle as a new error event: the new error wins and the flag reads 1.
- Reset mid-frame discards the partial frame and FIFO contents immediately.

Test Plan:
- CLKS_PER_BIT=16, 8N1. Send 0xA5 with rx_ready=0 -> rx_valid=1 one cycle after the stop sample; rx_data=0xA5; fifo_count=1. Pulse rx_ready -> count 0, rx_valid=0.
- FIFO_DEPTH=4, rx_ready=0. Send 0x01..0x05 back-to-back -> fifo_count=4 and overrun=1 after the fifth frame. Drain yields 0x01,0x02,0x03,0x04. clr_err clears overrun.
- FIFO full, with rx_ready=1 asserted exactly in the fifth frame's stop-sample cycle -> 0x01 popped, 0x05 stored, overrun=0, count=4.
- Send 0x3C with stop bit 0, then hold RX low 40 cycles -> frame_err=1, no push; receiver stays in BREAK until RX high; the next 0x55 is received correctly.
- PARITY=2. Send 0x03 with parity bit 1 -> parity_err=1, count 0. Send 0x03 with parity bit 0 -> stored 0x03.
- RX low pulse of 4 cycles (< 8) -> no frame, no flags. Assert rst_n=0 mid-frame with RX low, release with RX still low -> no frame until RX returns high and a new start arrives.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Receive-stream bundle between the UART receiver FIFO and its consumer.
// The receiver side (master) presents the FIFO head; the consumer (slave) returns ready.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]           rx_data;
    logic                           rx_valid;
    logic                           rx_ready;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;

    modport master (
        output rx_data,
        output rx_valid,
        output fifo_count,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  fifo_count,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with glitch-rejecting start detection, optional parity,
// a show-ahead receive FIFO and sticky frame/parity/overrun flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  iCE_CLK,
    input  logic                  rst_n,
    input  logic                  RX,
    input  logic                  clr_err,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    uart_rx_fifo_if.master        rxs
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int FW   = $clog2(SYNC_STAGES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BREAK
    } state_t;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (PARITY == 1) ? ~x : x;
    endfunction

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_q;
    logic [FW-1:0]          fill_cnt;
    logic                   fill_done;
    logic                   armed;
    logic                   fall;

    state_t                 state;
    logic [CW-1:0]          clk_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad;
    logic                   bit_tick;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CNTW-1:0]        count;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   do_push;
    logic                   stop_tick;

    assign rx_s      = sync[SYNC_STAGES-1];
    assign fill_done = (fill_cnt == FW'(SYNC_STAGES));
    assign fall      = armed & rx_q & ~rx_s;
    assign bit_tick  = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    // Synchroniser; the reset ones must be flushed before arming so a line
    // held low through reset release never looks like a start edge.
    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync     <= '1;
            rx_q     <= 1'b1;
            fill_cnt <= '0;
            armed    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], RX};
            rx_q <= rx_s;
            if (!fill_done)
                fill_cnt <= fill_cnt + FW'(1);
            if (fill_done && rx_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        par_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(DATA_BITS - 1))
                            state <= (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        par_bad <= parity_bad(shreg, rx_s);
                        state   <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                S_BREAK: begin
                    if (rx_s)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Frame outcome is decided in the stop-sample cycle; the FIFO and flags
    // absorb it on the same edge the FSM leaves STOP.
    assign stop_tick = (state == S_STOP) && bit_tick;
    assign push      = stop_tick & rx_s & ~par_bad;
    assign full      = (count == CNTW'(FIFO_DEPTH));
    assign pop       = rxs.rx_valid & rxs.rx_ready;
    assign do_push   = push & (~full | pop);

    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= shreg;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err takes priority.
    always_ff @(posedge iCE_CLK or negedge rst_n) begin
        if (!rst_n) begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (stop_tick && !rx_s)
                frame_err <= 1'b1;
            else if (clr_err)
                frame_err <= 1'b0;

            if (stop_tick && rx_s && par_bad)
                parity_err <= 1'b1;
            else if (clr_err)
                parity_err <= 1'b0;

            if (push && full && !pop)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end

    assign rxs.rx_data    = mem[rd_ptr];
    assign rxs.rx_valid   = (count != '0);
    assign rxs.fifo_count = count;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: an 8N1 instance and an even-parity instance,
// both at 16 clocks per bit, sharing clock and reset.
module tb_uart_rx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_n = 1'b1, rx_p = 1'b1;
    logic clr_n = 1'b0, clr_p = 1'b0;
    logic fe_n, pe_n, ov_n, fe_p, pe_p, ov_p;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_n ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) if_p ();

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_n (
        .iCE_CLK(clk), .rst_n(rst_n), .RX(rx_n), .clr_err(clr_n),
        .frame_err(fe_n), .parity_err(pe_n), .overrun(ov_n), .rxs(if_n)
    );

    uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4), .SYNC_STAGES(2)) u_p (
        .iCE_CLK(clk), .rst_n(rst_n), .RX(rx_p), .clr_err(clr_p),
        .frame_err(fe_p), .parity_err(pe_p), .overrun(ov_p), .rxs(if_p)
    );

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit sel, input logic v);
        if (sel) rx_p = v; else rx_n = v;
        wait_cyc(16);
    endtask

    task automatic send_head(input bit sel, input logic [7:0] d);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++)
            drive_bit(sel, d[i]);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input logic stop);
        send_head(sel, d);
        drive_bit(sel, stop);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, if_n.rx_data, exp);
        if_n.rx_ready = 1'b1;
        wait_cyc(1);
        if_n.rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        if_n.rx_ready = 1'b0;
        if_p.rx_ready = 1'b0;
        wait_cyc(3);
        check("rst_valid", if_n.rx_valid, 0);
        check("rst_count", if_n.fifo_count, 0);
        check("rst_data", if_n.rx_data, 0);
        check("rst_flags", {fe_n, pe_n, ov_n}, 0);
        rst_n = 1'b1;
        wait_cyc(10);

        // Single byte, exact push latency
        send_head(0, 8'hA5);
        rx_n = 1'b1;
        wait_cyc(10);
        check("pre_push_valid", if_n.rx_valid, 0);
        wait_cyc(1);
        check("push_valid", if_n.rx_valid, 1);
        check("push_data", if_n.rx_data, 8'hA5);
        check("push_count", if_n.fifo_count, 1);
        wait_cyc(5);
        if_n.rx_ready = 1'b1;
        wait_cyc(1);
        if_n.rx_ready = 1'b0;
        check("pop_count", if_n.fifo_count, 0);
        check("pop_valid", if_n.rx_valid, 0);
        if_n.rx_ready = 1'b1;
        wait_cyc(2);
        if_n.rx_ready = 1'b0;
        check("empty_pop_count", if_n.fifo_count, 0);

        // Overrun with five back-to-back frames
        for (int i = 1; i <= 5; i++)
            send_frame(0, 8'(i), 1'b1);
        check("ovr_count", if_n.fifo_count, 4);
        check("ovr_flag", ov_n, 1);
        pop_check("drain_01", 8'h01);
        pop_check("drain_02", 8'h02);
        pop_check("drain_03", 8'h03);
        pop_check("drain_04", 8'h04);
        check("drained_count", if_n.fifo_count, 0);
        clr_n = 1'b1;
        wait_cyc(1);
        clr_n = 1'b0;
        check("ovr_cleared", ov_n, 0);

        // Full FIFO, pop coincides with the fifth stop sample
        for (int i = 1; i <= 4; i++)
            send_frame(0, 8'(i), 1'b1);
        send_head(0, 8'h05);
        rx_n = 1'b1;
        wait_cyc(10);
        if_n.rx_ready = 1'b1;
        wait_cyc(1);
        if_n.rx_ready = 1'b0;
        wait_cyc(5);
        check("pp_overrun", ov_n, 0);
        check("pp_count", if_n.fifo_count, 4);
        pop_check("pp_02", 8'h02);
        pop_check("pp_03", 8'h03);
        pop_check("pp_04", 8'h04);
        pop_check("pp_05", 8'h05);

        // Framing error then break
        send_head(0, 8'h3C);
        wait_cyc(56);
        check("fe_flag", fe_n, 1);
        check("fe_count", if_n.fifo_count, 0);
        rx_n = 1'b1;
        wait_cyc(20);
        send_frame(0, 8'h55, 1'b1);
        check("after_brk_count", if_n.fifo_count, 1);
        pop_check("after_brk_data", 8'h55);
        clr_n = 1'b1;
        wait_cyc(1);
        clr_n = 1'b0;
        check("fe_cleared", fe_n, 0);

        // Even parity instance
        send_head(1, 8'h03);
        drive_bit(1, 1'b1);
        drive_bit(1, 1'b1);
        check("par_err", pe_p, 1);
        check("par_bad_count", if_p.fifo_count, 0);
        send_head(1, 8'h03);
        drive_bit(1, 1'b0);
        drive_bit(1, 1'b1);
        check("par_ok_count", if_p.fifo_count, 1);
        check("par_ok_data", if_p.rx_data, 8'h03);
        check("par_sticky", pe_p, 1);

        // Short glitch
        rx_n = 1'b0;
        wait_cyc(4);
        rx_n = 1'b1;
        wait_cyc(40);
        check("glitch_count", if_n.fifo_count, 0);
        check("glitch_flags", {fe_n, pe_n, ov_n}, 0);

        // Reset mid-frame with the line low
        rx_n = 1'b0;
        wait_cyc(50);
        rst_n = 1'b0;
        #1;
        check("async_rst_count_p", if_p.fifo_count, 0);
        check("async_rst_flag_p", pe_p, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(100);
        check("low_rel_count", if_n.fifo_count, 0);
        check("low_rel_flags", {fe_n, pe_n, ov_n}, 0);
        rx_n = 1'b1;
        wait_cyc(20);
        send_frame(0, 8'hC3, 1'b1);
        check("post_rst_count", if_n.fifo_count, 1);
        check("post_rst_data", if_n.rx_data, 8'hC3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
